// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB types, response codes and default memory map
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int AHB_SUBS   = 4;
    localparam int AHB_ADDR_W = 32;

    typedef logic [AHB_SUBS-1:0][AHB_ADDR_W-1:0] region_base_t;
    typedef logic [AHB_SUBS-1:0][AHB_ADDR_W-1:0] region_mask_t;

    // Regions 2/3 use mask 0 with a nonzero base so they can never match.
    localparam region_base_t DEFAULT_BASE = {32'h0000_0001, 32'h0000_0001,
                                             32'h1000_0000, 32'h0000_0000};
    localparam region_mask_t DEFAULT_MASK = {32'h0000_0000, 32'h0000_0000,
                                             32'hF000_0000, 32'hF000_0000};

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } def_state_t;

endpackage

// File: rtl/ahb_default_sub.sv
// rtl/ahb_default_sub.sv - default subordinate, two-cycle ERROR FSM for unmapped transfers
module ahb_default_sub
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sel_def,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       def_hreadyout,
    output logic       def_hresp
);

    def_state_t state_q, state_d;
    htrans_t    trans;
    logic       go;

    always_comb begin
        trans = htrans_t'(HTRANS);
        go    = sel_def && HREADY && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= D_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_OKAY;
        case (state_q)
            D_IDLE: begin
                if (go) state_d = D_ERR1;
            end
            D_ERR1: begin
                def_hreadyout = 1'b0;
                def_hresp     = HRESP_ERROR;
                state_d       = D_ERR2;
            end
            D_ERR2: begin
                def_hresp = HRESP_ERROR;
                state_d   = go ? D_ERR1 : D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_sub_decoder.sv
// rtl/ahb_sub_decoder.sv - HADDR decode, data-phase owner tracking and response mux
// AHB_DECODE_ERR_RESP_EN enables the two-cycle ERROR response for unmapped transfers.
module ahb_sub_decoder
    import ahb_pkg::*;
#(
    parameter int           SUBS   = AHB_SUBS,
    parameter int           ADDR_W = AHB_ADDR_W,
    parameter int           DATA_W = 32,
    parameter region_base_t BASE   = DEFAULT_BASE,
    parameter region_mask_t MASK   = DEFAULT_MASK
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [DATA_W-1:0]    HRDATA,
    output logic [SUBS-1:0]      HSEL,
    input  logic [SUBS-1:0]      S_HREADYOUT,
    input  logic [SUBS-1:0]      S_HRESP,
    input  logic [SUBS*DATA_W-1:0] S_HRDATA
);

    logic [SUBS-1:0] sel_q, sel_d;
    logic            def_q, def_d;
    logic            def_hreadyout;
    logic            def_hresp;
    logic            found;
    logic            active;
    htrans_t         trans;

    always_comb begin
        HSEL  = '0;
        found = 1'b0;
        for (int i = 0; i < SUBS; i++) begin
            if (!found && ((HADDR & MASK[i]) == BASE[i])) begin
                HSEL[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        trans  = htrans_t'(HTRANS);
        active = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
        sel_d  = sel_q;
        def_d  = def_q;
        // Owner only moves when the current data phase completes.
        if (HREADY) begin
            sel_d = active ? HSEL : '0;
            def_d = active && !found;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            def_q <= def_d;
        end
    end

`ifdef AHB_DECODE_ERR_RESP_EN
    logic sel_def;
    assign sel_def = ~|HSEL;

    ahb_default_sub u_default_sub (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .sel_def       (sel_def),
        .HTRANS        (HTRANS),
        .HREADY        (HREADY),
        .def_hreadyout (def_hreadyout),
        .def_hresp     (def_hresp)
    );
`else
    assign def_hreadyout = 1'b1;
    assign def_hresp     = HRESP_OKAY;
`endif

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < SUBS; i++) begin
            if (sel_q[i]) begin
                HREADY = S_HREADYOUT[i];
                HRESP  = S_HRESP[i];
                HRDATA = S_HRDATA[i*DATA_W +: DATA_W];
            end
        end
        if (def_q) begin
            HREADY = def_hreadyout;
            HRESP  = def_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_sub_decoder.sv
// tb/tb_ahb_sub_decoder.sv - scoreboard bench for ahb_sub_decoder on the default two-region map
module tb_ahb_sub_decoder;
    import ahb_pkg::*;

    logic         HCLK;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;
    logic [3:0]   HSEL;
    logic [3:0]   S_HREADYOUT;
    logic [3:0]   S_HRESP;
    logic [127:0] S_HRDATA;

    localparam logic [1:0]  NS = 2'b10;
    localparam logic [1:0]  SQ = 2'b11;
    localparam logic [1:0]  ID = 2'b00;
    localparam logic [1:0]  BS = 2'b01;
    localparam logic [31:0] D0 = 32'h5A5A_0000;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;

    ahb_sub_decoder dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .HSEL        (HSEL),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .S_HRDATA    (S_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int          idx;
        logic [3:0]  hsel;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_step = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("hsel@%0d", mon_e.idx),   {28'h0, HSEL},   {28'h0, mon_e.hsel});
            chk($sformatf("hready@%0d", mon_e.idx), {31'h0, HREADY}, {31'h0, mon_e.rdy});
            chk($sformatf("hresp@%0d", mon_e.idx),  {31'h0, HRESP},  {31'h0, mon_e.rsp});
            chk($sformatf("hrdata@%0d", mon_e.idx), HRDATA,          mon_e.data);
        end
    end

    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy,
                        input logic [3:0] rsp, input logic [3:0] ehsel, input logic erdy,
                        input logic ersp, input logic [31:0] edata);
        exp_t e;
        @(posedge HCLK);
        #1;
        HADDR       = a;
        HTRANS      = t;
        S_HREADYOUT = rdy;
        S_HRESP     = rsp;
        n_step++;
        e.idx  = n_step;
        e.hsel = ehsel;
        e.rdy  = erdy;
        e.rsp  = ersp;
        e.data = edata;
        sb.push_back(e);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        @(negedge HCLK);
        #1 HRESETn = 1'b0;
        #1;
        chk({tag, "_hready"}, {31'h0, HREADY}, 32'h1);
        chk({tag, "_hresp"},  {31'h0, HRESP},  32'h0);
        chk({tag, "_hrdata"}, HRDATA,          32'h0);
        #1 HRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn     = 1'b0;
        HADDR       = 32'h0;
        HTRANS      = ID;
        S_HREADYOUT = 4'hF;
        S_HRESP     = 4'h0;
        S_HRDATA    = {32'h3333_3333, 32'h2222_2222, D1, D0};
        #3;
        chk("rst_hready", {31'h0, HREADY}, 32'h1);
        chk("rst_hresp",  {31'h0, HRESP},  32'h0);
        chk("rst_hrdata", HRDATA,          32'h0);
        chk("rst_hsel",   {28'h0, HSEL},   32'h1);
        #9 HRESETn = 1'b1;

        // mapped zero-wait read from sub1
        step(32'h1000_0004, NS, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, D1);
        // BUSY / IDLE to mapped addresses leave no owner
        step(32'h0000_0020, BS, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
        step(32'h1000_0000, ID, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 32'h0);
        // sub0 with three wait states, pipelined sub1 address held off
        step(32'h0000_0010, NS, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(32'h1000_0008, NS, 4'b1110, 4'h0, 4'b0010, 1'b0, 1'b0, D0);
        step(32'h1000_0008, NS, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, D0);
        // sub1 ERROR is passed straight through
        step(32'h0000_0000, ID, 4'hF, 4'b0010, 4'b0001, 1'b1, 1'b1, D1);

`ifdef AHB_DECODE_ERR_RESP_EN
        step(32'h8000_0000, NS, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0010, NS, 4'hF, 4'h0, 4'b0001, 1'b0, 1'b1, 32'h0);
        step(32'h0000_0010, NS, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 32'h0);
        step(32'h9000_0000, SQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, D0);
        step(32'hA000_0000, NS, 4'hF, 4'h0, 4'b0000, 1'b0, 1'b1, 32'h0);
        step(32'hA000_0000, NS, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b1, 32'h0);
        step(32'h1000_0000, ID, 4'hF, 4'h0, 4'b0010, 1'b0, 1'b1, 32'h0);
        step(32'h1000_0000, ID, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b1, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
        // reset in the first ERROR cycle
        step(32'h8000_0000, NS, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b0, 1'b1, 32'h0);
        pulse_reset_and_check("rst_err1");
        step(32'h1000_0004, NS, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, D1);
`else
        step(32'h8000_0000, NS, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0010, NS, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
        step(32'h9000_0000, SQ, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, D0);
        step(32'h1000_0000, ID, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
`endif

        // reset during a subordinate wait state
        step(32'h0000_0010, NS, 4'hF,    4'h0, 4'b0001, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'b1110, 4'h0, 4'b0001, 1'b0, 1'b0, D0);
        pulse_reset_and_check("rst_wait");
        step(32'h1000_0004, NS, 4'hF, 4'h0, 4'b0010, 1'b1, 1'b0, 32'h0);
        step(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1'b1, 1'b0, D1);

        @(negedge HCLK);
        #1;
        chk("sb_drain", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
